// File: rtl/reg_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter.
// Contents: architectural register-file geometry, writeback source index
// constants, and a one-hot register decode helper used for the pending mask.
package reg_wb_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_NUM    = 32;
  localparam int REG_DATA_W = 32;

  localparam int SRC_ALU0 = 0;
  localparam int SRC_ALU1 = 1;
  localparam int SRC_LSU  = 2;
  localparam int SRC_MDU  = 3;

  typedef logic [REG_NUM-1:0] reg_mask_t;

  function automatic reg_mask_t reg_onehot(input logic [REG_ADDR_W-1:0] addr);
    reg_mask_t m;
    m       = '0;
    m[addr] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/reg_wb_arbiter_rr_pick2.sv
// Combinational two-winner rotating picker.
// Ports:
//   req      - request vector (one bit per source)
//   ptr      - rotating priority pointer; scan starts at this index
//   excl     - excl[w][j] set means source j may not take the second slot
//              when source w holds the first slot (address conflict)
//   win1_*   - first winner (valid flag and index)
//   win2_*   - second winner, scanned onward from the first winner
//   gnt      - one-hot OR of both winners
module rr_pick2 #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]          req,
  input  logic [IDX_W-1:0]      ptr,
  input  logic [N-1:0][N-1:0]   excl,
  output logic                  win1_vld,
  output logic [IDX_W-1:0]      win1_idx,
  output logic                  win2_vld,
  output logic [IDX_W-1:0]      win2_idx,
  output logic [N-1:0]          gnt
);

  always_comb begin
    logic [IDX_W-1:0] idx;
    idx      = '0;
    win1_vld = 1'b0;
    win1_idx = '0;
    win2_vld = 1'b0;
    win2_idx = '0;
    gnt      = '0;

    for (int k = 0; k < N; k++) begin
      idx = IDX_W'((int'(ptr) + k) % N);
      if (!win1_vld && req[idx]) begin
        win1_vld = 1'b1;
        win1_idx = idx;
      end
    end

    // Sources ahead of the first winner in rotation order did not request,
    // so continuing from the first winner covers the whole remaining order.
    if (win1_vld) begin
      for (int k = 1; k < N; k++) begin
        idx = IDX_W'((int'(win1_idx) + k) % N);
        if (!win2_vld && req[idx] && !excl[win1_idx][idx]) begin
          win2_vld = 1'b1;
          win2_idx = idx;
        end
      end
      gnt[win1_idx] = 1'b1;
    end
    if (win2_vld) gnt[win2_idx] = 1'b1;
  end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Writeback arbiter for the dual-write-port register file.
// Grants up to two writeback producers per cycle with rotating priority,
// never drives the same address on both ports, absorbs writes to r0, and
// registers the granted writes onto the register file ports (latency 1).
// Ports:
//   clk, rst_n            - clock, async active-low reset
//   wb_hold               - blocks all grants while high
//   src_valid/addr/data   - per-source write requests (flattened vectors)
//   src_ready             - per-source accept (combinational on src_valid)
//   reg_write_en          - bit0 = port 1, bit1 = port 2
//   reg_write_addr1/2     - port addresses
//   reg_write_data1/2     - port data
//   wb_pending            - one-hot OR of enabled port addresses
module reg_wb_arbiter
  import reg_wb_arbiter_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        wb_hold,
  input  logic [NUM_SRC-1:0]          src_valid,
  input  logic [NUM_SRC*ADDR_W-1:0]   src_addr,
  input  logic [NUM_SRC*DATA_W-1:0]   src_data,
  output logic [NUM_SRC-1:0]          src_ready,
  output logic [1:0]                  reg_write_en,
  output logic [ADDR_W-1:0]           reg_write_addr1,
  output logic [ADDR_W-1:0]           reg_write_addr2,
  output logic [DATA_W-1:0]           reg_write_data1,
  output logic [DATA_W-1:0]           reg_write_data2,
  output logic [31:0]                 wb_pending
);

  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [ADDR_W-1:0]              addr_a [NUM_SRC];
  logic [DATA_W-1:0]              data_a [NUM_SRC];
  logic [NUM_SRC-1:0]             req_wr;
  logic [NUM_SRC-1:0]             req_r0;
  logic [NUM_SRC-1:0][NUM_SRC-1:0] conflict;

  logic                           win1_vld;
  logic [IDX_W-1:0]               win1_idx;
  logic                           win2_vld;
  logic [IDX_W-1:0]               win2_idx;
  logic [NUM_SRC-1:0]             gnt;

  logic [1:0]                     en_q, en_d;
  logic [ADDR_W-1:0]              addr1_q, addr1_d;
  logic [ADDR_W-1:0]              addr2_q, addr2_d;
  logic [DATA_W-1:0]              data1_q, data1_d;
  logic [DATA_W-1:0]              data2_q, data2_d;
  logic [31:0]                    pending_q, pending_d;
  logic [IDX_W-1:0]               rr_ptr_q, rr_ptr_d;

  function automatic logic [IDX_W-1:0] ptr_after(input logic [IDX_W-1:0] idx);
    return (idx == IDX_W'(NUM_SRC - 1)) ? '0 : idx + 1'b1;
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      addr_a[i] = src_addr[i*ADDR_W +: ADDR_W];
      data_a[i] = src_data[i*DATA_W +: DATA_W];
      req_wr[i] = src_valid[i] && (addr_a[i] != '0);
      req_r0[i] = src_valid[i] && (addr_a[i] == '0);
    end
    for (int w = 0; w < NUM_SRC; w++) begin
      for (int j = 0; j < NUM_SRC; j++) begin
        conflict[w][j] = (addr_a[w] == addr_a[j]);
      end
    end
  end

  rr_pick2 #(
    .N     (NUM_SRC),
    .IDX_W (IDX_W)
  ) u_pick (
    .req      (req_wr),
    .ptr      (rr_ptr_q),
    .excl     (conflict),
    .win1_vld (win1_vld),
    .win1_idx (win1_idx),
    .win2_vld (win2_vld),
    .win2_idx (win2_idx),
    .gnt      (gnt)
  );

  // r0 requests are accepted and silently dropped; they never touch a port.
  assign src_ready = (rst_n && !wb_hold) ? (gnt | req_r0) : '0;

  always_comb begin
    en_d     = '0;
    addr1_d  = addr1_q;
    addr2_d  = addr2_q;
    data1_d  = data1_q;
    data2_d  = data2_q;
    rr_ptr_d = rr_ptr_q;

    if (!wb_hold && win1_vld) begin
      en_d[0]  = 1'b1;
      addr1_d  = addr_a[win1_idx];
      data1_d  = data_a[win1_idx];
      rr_ptr_d = ptr_after(win1_idx);
    end
    if (!wb_hold && win2_vld) begin
      en_d[1]  = 1'b1;
      addr2_d  = addr_a[win2_idx];
      data2_d  = data_a[win2_idx];
      rr_ptr_d = ptr_after(win2_idx);
    end

    pending_d = '0;
    if (en_d[0]) pending_d = pending_d | reg_onehot(REG_ADDR_W'(addr1_d));
    if (en_d[1]) pending_d = pending_d | reg_onehot(REG_ADDR_W'(addr2_d));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q      <= '0;
      addr1_q   <= '0;
      addr2_q   <= '0;
      data1_q   <= '0;
      data2_q   <= '0;
      pending_q <= '0;
      rr_ptr_q  <= '0;
    end else begin
      en_q      <= en_d;
      addr1_q   <= addr1_d;
      addr2_q   <= addr2_d;
      data1_q   <= data1_d;
      data2_q   <= data2_d;
      pending_q <= pending_d;
      rr_ptr_q  <= rr_ptr_d;
    end
  end

  assign reg_write_en    = en_q;
  assign reg_write_addr1 = addr1_q;
  assign reg_write_addr2 = addr2_q;
  assign reg_write_data1 = data1_q;
  assign reg_write_data2 = data2_q;
  assign wb_pending      = pending_q;

endmodule

// File: doc/reg_wb_arbiter.md
Name: reg_wb_arbiter

Overview:
- Shares the dual-write-port register file between up to NUM_SRC writeback producers (ALU0, ALU1, LSU, MUL/DIV).
- Each cycle it grants at most two requests using rotating round-robin priority.
- It resolves same-cycle same-address conflicts and discards writes to r0.
- Writes are registered and driven onto the register file write ports one cycle after the handshake.

Parameters:
- NUM_SRC, 4, number of writeback requesters (2..8)
- DATA_W, 32, write data width
- ADDR_W, 5, register address width (32 architectural registers)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- wb_hold  input  1  pipeline hold; blocks all grants while high
- src_valid  input  NUM_SRC  per-source write request
- src_addr  input  NUM_SRC*ADDR_W  per-source destination register, source i at [i*ADDR_W +: ADDR_W]
- src_data  input  NUM_SRC*DATA_W  per-source write data, source i at [i*DATA_W +: DATA_W]
- src_ready  output  NUM_SRC  per-source accept; transfer when valid&ready
- reg_write_en  output  2  write enables; bit0 = port 1, bit1 = port 2
- reg_write_addr1  output  ADDR_W  port 1 address
- reg_write_addr2  output  ADDR_W  port 2 address
- reg_write_data1  output  DATA_W  port 1 data
- reg_write_data2  output  DATA_W  port 2 data
- wb_pending  output  32  one-hot OR of the addresses currently driven with an enable; used by the issue bypass logic

Behaviour:
- Reset (async, rst_n=0):
  - reg_write_en=0, addr/data outputs=0, wb_pending=0, rr_ptr=0.
  - src_ready=0 while reset is asserted.
- Grant selection (combinational, evaluated each cycle when wb_hold=0):
  - Scan sources in order rr_ptr, rr_ptr+1, … (mod NUM_SRC).
  - First valid source with addr!=0 → port 1.
  - Next valid source with addr!=0 and addr != port-1 address → port 2.
  - A valid source whose address equals the port-1 address is not granted; it waits.
  - Every valid source with addr==0 gets ready=1, consumes no port and produces no write.
- src_ready:
  - src_ready[i]=1 iff source i is granted or is a valid r0 request.
  - src_ready depends combinationally on src_valid; sources must not make src_valid depend on src_ready.
  - Once raised, a source holds valid, addr and data stable until its handshake.
- wb_hold=1:
  - All src_ready=0 and no grants.
  - Next cycle reg_write_en=0; rr_ptr holds.
- Output stage (registered, latency 1):
  - On the clk edge after a handshake, reg_write_en[k]=1 with the granted addr/data on port k+1.
  - Only port 2 granted is impossible; port 1 always fills first.
  - With no grant, reg_write_en=0 and addr/data keep their previous values (don't-care).
- rr_ptr update:
  - If ≥1 port was granted: rr_ptr = (index of last port-granted source + 1) mod NUM_SRC.
  - Otherwise rr_ptr holds.
  - r0-only handshakes do not move rr_ptr.
- Fairness: a continuously valid, non-conflicting source is granted within NUM_SRC cycles.
- wb_pending = decode(addr1)&en[0] | decode(addr2)&en[1]; registered alongside the ports; bit 0 never set.
- Guarantee: the two ports never carry the same address in one cycle, so the register file port write order is irrelevant.
- Reset mid-transfer: in-flight output-stage writes are dropped; sources must re-present after reset.

Decomposition:
- Shared package holds:
  - REG_ADDR_W=5, REG_NUM=32, REG_DATA_W=32
  - source index constants SRC_ALU0=0, SRC_ALU1=1, SRC_LSU=2, SRC_MDU=3
- One sub-module, rr_pick2: combinational two-winner rotating picker with exclusion mask, taking request vector, pointer and address-conflict mask.
- The output register stage, pointer register and pending decode stay in reg_wb_arbiter.

Test Plan:
- Reset, then single request: src0 valid addr=5 data=0x11111111 → ready0=1 same cycle; next cycle en=01, addr1=5, data1=0x11111111, wb_pending=0x20; rr_ptr=1.
- Three sources valid (addr 3, 4, 6), rr_ptr=0:
  - Cycle 0: src0 → port 1, src1 → port 2, src2 ready=0.
  - Cycle 1: src2 → port 1; rr_ptr ends at 3.
- Same address: src1 and src2 valid, both addr=7, rr_ptr=1 → src1 on port 1, src2 waits; next cycle src2 on port 1; en=01 both cycles.
- r0 write: src3 valid addr=0 with src0 addr=9 → both ready=1; next cycle en=01, addr1=9; no r0 write; rr_ptr=1.
- Hold and fairness:
  - wb_hold=1 with all four valid → all ready=0; next cycle en=00; rr_ptr unchanged.
  - Release with all four held valid and distinct addresses → each source granted within 2 cycles.
- Async reset asserted mid-cycle with en=11 → outputs and wb_pending clear immediately without waiting for clk.
